// File: rtl/ofm_writer_pkg.sv
// Shared types and sizing helpers for the OFM RAM writer.
// The localparams give the default geometry; the functions size a given instance.
package ofm_writer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    localparam int WOUT_DEF   = 64;
    localparam int DSP_NO_DEF = 16;
    localparam int PIX_TOTAL  = WOUT_DEF * WOUT_DEF;
    localparam int ADDR_W_DEF = $clog2(DSP_NO_DEF * PIX_TOTAL);

    // Width helper that never returns zero, so that degenerate geometries still yield legal vectors.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic int pix_total(input int wout);
        return wout * wout;
    endfunction

    function automatic int addr_width(input int dsp_no, input int wout);
        return clog2_min1(dsp_no * wout * wout);
    endfunction

endpackage

// File: rtl/ofm_slot_fifo.sv
// Two-entry FIFO of full ofm vectors, each tagged with its pixel index.
// It also exposes the head as it will be after the next edge, so the writer can preload its output registers.
module ofm_slot_fifo
    import ofm_writer_pkg::*;
#(
    parameter int DSP_NO = DSP_NO_DEF,
    parameter int WIDTH  = 16,
    parameter int TAG_W  = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i [DSP_NO],
    input  logic [TAG_W-1:0] tag_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [TAG_W-1:0] head_tag_o,
    output logic             nxt_valid_o,
    output logic [WIDTH-1:0] nxt_data_o [DSP_NO],
    output logic [TAG_W-1:0] nxt_tag_o,
    output logic             nxt_busy_o
);

    logic [WIDTH-1:0] slot_q [2][DSP_NO];
    logic [TAG_W-1:0] tag_q  [2];
    logic [1:0]       valid_q, valid_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             bypass;

    // Pop is cleared before push is applied, so a push into the slot being freed leaves it valid.
    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        bypass      = push_i && (wr_ptr_q == rd_ptr_d);
        nxt_valid_o = valid_d[rd_ptr_d];
        nxt_busy_o  = |valid_d;
        nxt_tag_o   = bypass ? tag_i : tag_q[rd_ptr_d];
        for (int c = 0; c < DSP_NO; c++) begin
            nxt_data_o[c] = bypass ? data_i[c] : slot_q[rd_ptr_d][c];
        end
    end

    assign full_o     = &valid_q;
    assign empty_o    = ~|valid_q;
    assign head_tag_o = tag_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                tag_q[s] <= '0;
                for (int c = 0; c < DSP_NO; c++) begin
                    slot_q[s][c] <= '0;
                end
            end
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i) begin
                tag_q[wr_ptr_q] <= tag_i;
                for (int c = 0; c < DSP_NO; c++) begin
                    slot_q[wr_ptr_q][c] <= data_i[c];
                end
            end
        end
    end

endmodule

// File: rtl/ofm_ram_writer.sv
// Captures per-pixel ofm vectors from a conv layer and writes them channel-major into the feature-map RAM.
// The RAM port registers always hold the word being written in the current cycle, which is loaded from the FIFO's next-head view.
module ofm_ram_writer
    import ofm_writer_pkg::*;
#(
    parameter int WOUT   = WOUT_DEF,
    parameter int DSP_NO = DSP_NO_DEF,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = addr_width(DSP_NO, WOUT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              layer_sample_i,
    input  logic [WIDTH-1:0]  ofm_in_i [DSP_NO],
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WIDTH-1:0]  ram_wdata_o,
    output logic              ram_feedback_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int PIX_N = pix_total(WOUT);
    localparam int CH_W  = clog2_min1(DSP_NO);
    localparam int TAG_W = clog2_min1(PIX_N);
    localparam int ACC_W = $clog2(PIX_N + 1);

    wr_state_e         state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic              feedback_q, feedback_d;
    logic              busy_q;
    logic              overflow_q, overflow_d;

    logic              fifo_full, fifo_empty, head_valid;
    logic              pop, accept, drop, last_pix_done;
    logic [TAG_W-1:0]  head_tag, nxt_tag;
    logic              nxt_valid, nxt_busy;
    logic [WIDTH-1:0]  nxt_data [DSP_NO];

    ofm_slot_fifo #(
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH),
        .TAG_W  (TAG_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .pop_i       (pop),
        .data_i      (ofm_in_i),
        .tag_i       (TAG_W'(acc_q)),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_tag_o  (head_tag),
        .nxt_valid_o (nxt_valid),
        .nxt_data_o  (nxt_data),
        .nxt_tag_o   (nxt_tag),
        .nxt_busy_o  (nxt_busy)
    );

    // The last word of the head slot is on the RAM port this cycle, so its slot can be reused at this edge.
    always_comb begin
        head_valid    = ~fifo_empty;
        pop           = head_valid && (ch_q == CH_W'(DSP_NO - 1));
        accept        = layer_sample_i && (state_q == ST_RUN) && (acc_q < ACC_W'(PIX_N))
                        && (!fifo_full || pop);
        drop          = layer_sample_i && (state_q == ST_RUN) && fifo_full && !pop;
        last_pix_done = pop && (head_tag == TAG_W'(PIX_N - 1));
    end

    always_comb begin
        state_d    = state_q;
        feedback_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (accept && (acc_q == ACC_W'(PIX_N - 1))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (last_pix_done) begin
                    state_d    = ST_DONE;
                    feedback_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        acc_d       = acc_q + ACC_W'(accept);
        overflow_d  = overflow_q | drop;
        ch_d        = (head_valid && !pop) ? ch_q + CH_W'(1) : '0;
        ram_we_d    = nxt_valid;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        if (nxt_valid) begin
            ram_addr_d  = ADDR_W'(ch_d) * ADDR_W'(PIX_N) + ADDR_W'(nxt_tag);
            ram_wdata_d = nxt_data[ch_d];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            ch_q        <= '0;
            acc_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            feedback_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            feedback_q  <= feedback_d;
            busy_q      <= nxt_busy;
            overflow_q  <= overflow_d;
        end
    end

    assign ram_we_o       = ram_we_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_wdata_o    = ram_wdata_q;
    assign ram_feedback_o = feedback_q;
    assign busy_o         = busy_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_ofm_ram_writer.sv
// Self-checking bench for ofm_ram_writer at WOUT=2, DSP_NO=4, WIDTH=16.
// Expected RAM writes are queued when a sample is driven and checked as the DUT writes them.
module tb_ofm_ram_writer;
    import ofm_writer_pkg::*;

    localparam int WOUT   = 2;
    localparam int DSP_NO = 4;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PIX    = WOUT * WOUT;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    typedef struct {
        bit          rstBefore;
        int          gap;
        logic [63:0] ofm;
        bit          expAccept;
        int          pix;
        bit          expOvf;
    } vec_t;

    logic              clk;
    logic              rstN;
    logic              layerSample;
    logic [WIDTH-1:0]  ofmIn [DSP_NO];
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [WIDTH-1:0]  ramWdata;
    logic              ramFeedback;
    logic              busy;
    logic              overflow;

    int  nChecks = 0;
    int  nFail   = 0;
    int  cyc     = 0;
    int  nWrites = 0;
    int  lastWriteCyc = 0;
    int  gaps    = 0;
    int  fbCount = 0;
    int  fbCyc   = 0;
    int  lastSampleCyc = 0;
    int  sCyc;
    wr_t expQ [$];
    wr_t monE;
    vec_t vecs [13];

    ofm_ram_writer #(
        .WOUT   (WOUT),
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .layer_sample_i (layerSample),
        .ofm_in_i       (ofmIn),
        .ram_we_o       (ramWe),
        .ram_addr_o     (ramAddr),
        .ram_wdata_o    (ramWdata),
        .ram_feedback_o (ramFeedback),
        .busy_o         (busy),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ramWe) begin
            if (nWrites > 0 && cyc != lastWriteCyc + 1) gaps++;
            nWrites++;
            lastWriteCyc = cyc;
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected_write: addr %0h data %0h, no write was due", ramAddr, ramWdata);
            end else begin
                monE = expQ.pop_front();
                checkOutput("wr_addr", 32'(ramAddr), 32'(monE.addr));
                checkOutput("wr_data", 32'(ramWdata), 32'(monE.data));
            end
        end
        if (ramFeedback) begin
            fbCount++;
            fbCyc = cyc;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"}, 32'(ramWe), 0);
        checkOutput({tag, "_addr"}, 32'(ramAddr), 0);
        checkOutput({tag, "_wdata"}, 32'(ramWdata), 0);
        checkOutput({tag, "_fb"}, 32'(ramFeedback), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rstN        = 1'b0;
        layerSample = 1'b0;
        expQ.delete();
        nWrites = 0;
        gaps    = 0;
        fbCount = 0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // Drives one sample for one cycle; returns at the negedge of the following cycle.
    task automatic applyStimulus(input logic [63:0] ofm, input bit expAccept, input int pix, output int sampleCyc);
        layerSample = 1'b1;
        for (int c = 0; c < DSP_NO; c++) ofmIn[c] = ofm[16*c +: 16];
        sampleCyc = cyc;
        if (expAccept) begin
            for (int c = 0; c < DSP_NO; c++) begin
                expQ.push_back('{addr: ADDR_W'(c * PIX + pix), data: ofm[16*c +: 16]});
            end
        end
        @(negedge clk);
        layerSample = 1'b0;
    endtask

    task automatic runVectors(input int lo, input int hi);
        int sc;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].rstBefore) resetDut();
            repeat (vecs[i].gap) @(negedge clk);
            applyStimulus(vecs[i].ofm, vecs[i].expAccept, vecs[i].pix, sc);
            if (vecs[i].expAccept) lastSampleCyc = sc;
            checkOutput("ovf_vec", 32'(overflow), 32'(vecs[i].expOvf));
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rstN        = 1'b0;
        layerSample = 1'b0;
        for (int c = 0; c < DSP_NO; c++) ofmIn[c] = '0;

        // Four pixels 10 cycles apart, then three samples after completion, then overflow and boundary-accept cases.
        vecs[0]  = '{1'b1, 3, pack4(0, 1, 2, 3),         1'b1, 0, 1'b0};
        vecs[1]  = '{1'b0, 9, pack4(10, 11, 12, 13),     1'b1, 1, 1'b0};
        vecs[2]  = '{1'b0, 9, pack4(20, 21, 22, 23),     1'b1, 2, 1'b0};
        vecs[3]  = '{1'b0, 9, pack4(30, 31, 32, 33),     1'b1, 3, 1'b0};
        vecs[4]  = '{1'b0, 2, pack4(7, 7, 7, 7),         1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 0, pack4(8, 8, 8, 8),         1'b0, 0, 1'b0};
        vecs[6]  = '{1'b0, 3, pack4(9, 9, 9, 9),         1'b0, 0, 1'b0};
        vecs[7]  = '{1'b1, 3, pack4(100, 101, 102, 103), 1'b1, 0, 1'b0};
        vecs[8]  = '{1'b0, 0, pack4(110, 111, 112, 113), 1'b1, 1, 1'b0};
        vecs[9]  = '{1'b0, 0, pack4(120, 121, 122, 123), 1'b0, 0, 1'b1};
        vecs[10] = '{1'b1, 3, pack4(200, 201, 202, 203), 1'b1, 0, 1'b0};
        vecs[11] = '{1'b0, 0, pack4(210, 211, 212, 213), 1'b1, 1, 1'b0};
        vecs[12] = '{1'b0, 2, pack4(220, 221, 222, 223), 1'b1, 2, 1'b0};

        // Single sample: writes and busy in the four cycles after it, idle after.
        resetDut();
        repeat (3) @(negedge clk);
        applyStimulus(pack4(1, 2, 3, 4), 1'b1, 0, sCyc);
        for (int d = 1; d <= 5; d++) begin
            checkOutput("single_we", 32'(ramWe), (d <= 4) ? 1 : 0);
            checkOutput("single_busy", 32'(busy), (d <= 4) ? 1 : 0);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput("single_nwrites", nWrites, 4);
        checkOutput("single_fb", fbCount, 0);

        // Full layer of four pixels.
        runVectors(0, 3);
        repeat (8) @(negedge clk);
        checkOutput("layer_nwrites", nWrites, 16);
        checkOutput("layer_sb_empty", expQ.size(), 0);
        checkOutput("layer_last_write", lastWriteCyc, lastSampleCyc + 4);
        checkOutput("layer_fb_count", fbCount, 1);
        checkOutput("layer_fb_cyc", fbCyc, lastSampleCyc + 5);
        checkOutput("layer_state", 32'(dut.state_q), 32'(ST_DONE));

        // Samples after completion are ignored.
        runVectors(4, 6);
        repeat (8) @(negedge clk);
        checkOutput("done_nwrites", nWrites, 16);
        checkOutput("done_fb_count", fbCount, 1);
        checkOutput("done_we", 32'(ramWe), 0);

        // Three back-to-back samples: third dropped, overflow sticky.
        runVectors(7, 9);
        repeat (12) @(negedge clk);
        checkOutput("ovf_nwrites", nWrites, 8);
        checkOutput("ovf_gaps", gaps, 0);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        checkOutput("ovf_sb_empty", expQ.size(), 0);

        // Third sample lands as the head slot's last word issues.
        runVectors(10, 12);
        repeat (16) @(negedge clk);
        checkOutput("edge_nwrites", nWrites, 12);
        checkOutput("edge_gaps", gaps, 0);
        checkOutput("edge_ovf", 32'(overflow), 0);
        checkOutput("edge_sb_empty", expQ.size(), 0);

        // Reset in the middle of a drain.
        resetDut();
        repeat (3) @(negedge clk);
        applyStimulus(pack4(5, 6, 7, 8), 1'b1, 0, sCyc);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkResetOutputs("midrst");
        checkOutput("midrst_nwrites", nWrites, 2);
        expQ.delete();
        nWrites = 0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_quiet", nWrites, 0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(pack4(9, 10, 11, 12), 1'b1, 0, sCyc);
        repeat (8) @(negedge clk);
        checkOutput("restart_nwrites", nWrites, 4);
        checkOutput("restart_sb_empty", expQ.size(), 0);
        checkOutput("restart_fb", fbCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
